// File: rtl/accum_int_multi.sv
// accum_int_multi: multi-channel signed lane accumulator.
// Each issued op reduces LANES lanes plus a scalar through a three-stage
// pipelined adder tree. The reduced sum is then applied to one of CH
// accumulator channels as SUM, ACC, LOAD or RDCLR, using wrap or saturate
// arithmetic. The result is driven onto a shared tri-stated bus.
module accum_int_multi #(
    parameter int WIDTH = 64,
    parameter int LANES = 108,
    parameter int GRP   = 12,
    parameter int CH    = 4,
    parameter int GUARD = 8,
    localparam int RW   = WIDTH + GUARD,
    localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             A,
    input  logic [LANES-1:0][WIDTH-1:0]  B,
    input  logic                         din_en,
    input  logic [1:0]                   op,
    input  logic [CHW-1:0]               ch,
    input  logic                         sat,
    output logic                         res_en,
    output logic [RW-1:0]                res,
    output logic                         res_ovf
);

    localparam int NG = LANES / GRP;

    localparam logic [RW-1:0] MAXV = {1'b0, {(RW-1){1'b1}}};
    localparam logic [RW-1:0] MINV = {1'b1, {(RW-1){1'b0}}};

    typedef enum logic [1:0] {
        OP_SUM   = 2'd0,
        OP_ACC   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_RDCLR = 2'd3
    } op_e;

    // Illegal parameter combinations are rejected at elaboration.
    // The guard bits must absorb the growth of LANES+1 summed operands.
    if (LANES % GRP != 0) begin : g_bad_grp
        $error("accum_int_multi: LANES must be a multiple of GRP");
    end
    if (CH < 2) begin : g_bad_ch
        $error("accum_int_multi: CH must be at least 2");
    end
    if (LANES + 1 > 2 ** GUARD) begin : g_bad_guard
        $error("accum_int_multi: GUARD too small, S could overflow");
    end

    function automatic logic [RW-1:0] sext(input logic [WIDTH-1:0] x);
        return {{GUARD{x[WIDTH-1]}}, x};
    endfunction

    // ---------------- stage 1: group partial sums ----------------
    logic [RW-1:0]  part_d [NG];
    logic [RW-1:0]  grp_sum;

    logic           v1;
    op_e            op1;
    logic [CHW-1:0] ch1;
    logic           sat1;
    logic [RW-1:0]  a1;
    logic [RW-1:0]  part1 [NG];

    // Sum each group of GRP sign-extended lanes.
    always_comb begin
        // NOTE: every comb output gets a value on every path; a missed branch would infer a latch.
        grp_sum = '0;
        for (int g = 0; g < NG; g++) begin
            grp_sum = '0;
            for (int l = 0; l < GRP; l++) begin
                grp_sum = grp_sum + sext(B[g*GRP + l]);
            end
            part_d[g] = grp_sum;
        end
    end

    // Register the partials and the control fields of an issued op.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            v1   <= 1'b0;
            op1  <= OP_SUM;
            ch1  <= '0;
            sat1 <= 1'b0;
            a1   <= '0;
            for (int g = 0; g < NG; g++) part1[g] <= '0;
        end else begin
            v1 <= din_en;
            if (din_en) begin
                op1  <= op_e'(op);
                ch1  <= ch;
                sat1 <= sat;
                a1   <= sext(A);
                for (int g = 0; g < NG; g++) part1[g] <= part_d[g];
            end
        end
    end

    // ---------------- stage 2: final reduction S ----------------
    logic [RW-1:0]  s_d;

    logic           v2;
    op_e            op2;
    logic [CHW-1:0] ch2;
    logic           sat2;
    logic [RW-1:0]  s2;

    // Add the scalar to all group partials.
    always_comb begin
        s_d = a1;
        for (int g = 0; g < NG; g++) s_d = s_d + part1[g];
    end

    // Register S and forward the op fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2   <= 1'b0;
            op2  <= OP_SUM;
            ch2  <= '0;
            sat2 <= 1'b0;
            s2   <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                op2  <= op1;
                ch2  <= ch1;
                sat2 <= sat1;
                s2   <= s_d;
            end
        end
    end

    // ---------------- stage 3: accumulator update ----------------
    logic [RW-1:0] acc [CH];

    logic          ch_ok;
    logic [RW-1:0] cur;
    logic [RW-1:0] sum_t;
    logic          add_ovf;
    logic [RW-1:0] acc_val;
    op_e           eff_op;
    logic [RW-1:0] r_d;
    logic          ovf_d;
    logic          wr;
    logic [RW-1:0] wdata;

    logic          v3;
    logic [RW-1:0] r3;
    logic          ovf3;

    // Channel numbers beyond CH can only occur when CH is not a power of two.
    if ((1 << CHW) == CH) begin : g_ch_full
        assign ch_ok = 1'b1;
    end else begin : g_ch_partial
        assign ch_ok = (int'(ch2) < CH);
    end

    // Compute the result and the accumulator write for the op in stage 3.
    always_comb begin
        cur     = ch_ok ? acc[ch2] : '0;
        sum_t   = cur + s2;
        add_ovf = (cur[RW-1] == s2[RW-1]) && (sum_t[RW-1] != cur[RW-1]);
        if (sat2 && add_ovf) acc_val = cur[RW-1] ? MINV : MAXV;
        else                 acc_val = sum_t;
        eff_op  = ch_ok ? op2 : OP_SUM;
        r_d     = s2;
        ovf_d   = 1'b0;
        wr      = 1'b0;
        wdata   = '0;
        case (eff_op)
            OP_SUM: begin
            end
            OP_ACC: begin
                r_d   = acc_val;
                ovf_d = add_ovf;
                wr    = 1'b1;
                wdata = acc_val;
            end
            OP_LOAD: begin
                wr    = 1'b1;
                wdata = s2;
            end
            OP_RDCLR: begin
                r_d   = cur;
                wr    = 1'b1;
                wdata = '0;
            end
            default: begin
            end
        endcase
    end

    // Read-modify-write the target channel and capture the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the accumulator array is architectural state, so each entry is reset explicitly.
            for (int c = 0; c < CH; c++) acc[c] <= '0;
            v3   <= 1'b0;
            r3   <= '0;
            ovf3 <= 1'b0;
        end else begin
            v3 <= v2;
            if (v2) begin
                r3   <= r_d;
                ovf3 <= ovf_d;
                if (wr) acc[ch2] <= wdata;
            end
        end
    end

    assign res_en = v3;

    // ---------------- output register and bus drive ----------------
    logic          res_v;
    logic [RW-1:0] res_q;
    logic          ovf_q;

    // Hold the result for one beat on the shared bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_v <= 1'b0;
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            res_v <= v3;
            if (v3) begin
                res_q <= r3;
                ovf_q <= ovf3;
            end
        end
    end

    assign res     = res_v ? res_q : {RW{1'bz}};
    assign res_ovf = res_v ? ovf_q : 1'bz;

endmodule

// File: tb/tb_accum_int_multi.sv
// Self-checking bench for accum_int_multi: directed cases followed by a
// random full-rate stream. All results are checked against a behavioural
// model of the accumulator channels.
module tb_accum_int_multi;

    localparam int WIDTH = 64;
    localparam int LANES = 108;
    localparam int GRP   = 12;
    localparam int CH    = 4;
    localparam int GUARD = 8;
    localparam int RW    = WIDTH + GUARD;
    localparam int CHW   = 2;

    localparam logic [1:0] SUM   = 2'd0;
    localparam logic [1:0] ACC   = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] RDCLR = 2'd3;

    localparam logic signed [RW:0] MAXV = {2'b00, {(RW-1){1'b1}}};
    localparam logic signed [RW:0] MINV = {2'b11, {(RW-1){1'b0}}};

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [WIDTH-1:0]            A = '0;
    logic [LANES-1:0][WIDTH-1:0] B = '0;
    logic                        din_en = 1'b0;
    logic [1:0]                  op = '0;
    logic [CHW-1:0]              ch = '0;
    logic                        sat = 1'b0;
    wire                         res_en;
    wire  [RW-1:0]               res;
    wire                         res_ovf;

    accum_int_multi #(
        .WIDTH(WIDTH), .LANES(LANES), .GRP(GRP), .CH(CH), .GUARD(GUARD)
    ) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .din_en(din_en), .op(op),
        .ch(ch), .sat(sat), .res_en(res_en), .res(res), .res_ovf(res_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [RW-1:0] val;
        logic          ovf;
    } exp_t;

    exp_t                  exp_q[$];
    logic signed [RW-1:0]  m_acc [CH];

    task automatic model_issue(input logic [1:0] o, input int c, input logic s);
        logic signed [RW-1:0] ssum;
        logic signed [RW:0]   t;
        exp_t                 e;
        ssum = $signed(A);
        for (int i = 0; i < LANES; i++) ssum = ssum + $signed(B[i]);
        e.ovf = 1'b0;
        e.val = ssum;
        case (o)
            ACC: begin
                t = m_acc[c] + ssum;
                if (t > MAXV) begin
                    e.ovf = 1'b1;
                    e.val = s ? MAXV[RW-1:0] : t[RW-1:0];
                end else if (t < MINV) begin
                    e.ovf = 1'b1;
                    e.val = s ? MINV[RW-1:0] : t[RW-1:0];
                end else begin
                    e.val = t[RW-1:0];
                end
                m_acc[c] = e.val;
            end
            LOAD:  m_acc[c] = ssum;
            RDCLR: begin
                e.val    = m_acc[c];
                m_acc[c] = '0;
            end
            default: begin
            end
        endcase
        exp_q.push_back(e);
    endtask

    // ---------------- output monitor ----------------
    int            cyc = 0;
    int            n_en = 0;
    int            en_cyc[$];
    logic [RW-1:0] obs_res[$];
    logic          obs_ovf[$];
    logic          prev_en = 1'b0;
    exp_t          me;

    always @(posedge clk) cyc++;

    // A res_en seen on one falling edge means res must be valid on the next.
    always @(negedge clk) begin
        if (prev_en) begin
            if (exp_q.size() == 0) begin
                check("spurious_res", 1'b1, 1'b0);
            end else begin
                me = exp_q.pop_front();
                check("res", res, me.val);
                check("ovf", res_ovf, me.ovf);
            end
            obs_res.push_back(res);
            obs_ovf.push_back(res_ovf);
        end else begin
            check("res_z", res === {RW{1'bz}}, 1'b1);
            check("ovf_z", res_ovf === 1'bz, 1'b1);
        end
        if (res_en === 1'b1) begin
            n_en++;
            en_cyc.push_back(cyc);
        end
        prev_en = (res_en === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    int issue_cyc;

    task automatic set_b_all(input logic [WIDTH-1:0] v);
        for (int i = 0; i < LANES; i++) B[i] = v;
    endtask

    task automatic clear_log();
        obs_res.delete();
        obs_ovf.delete();
        en_cyc.delete();
    endtask

    // Called 2 ns after a rising edge; returns 2 ns after the sampling edge.
    task automatic issue(input logic [1:0] o, input int c, input logic s);
        op     = o;
        ch     = c[CHW-1:0];
        sat    = s;
        din_en = 1'b1;
        model_issue(o, c, s);
        issue_cyc = cyc;
        @(posedge clk);
        #2;
        din_en = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        repeat (2) @(posedge clk);
        #2;
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < CH; c++) m_acc[c] = '0;
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    logic [RW-1:0] wrap4;
    int            n_en0;

    initial begin
        for (int c = 0; c < CH; c++) m_acc[c] = '0;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_res_en", res_en, 1'b0);
        check("rst_res_z", res === {RW{1'bz}}, 1'b1);
        check("rst_ovf_z", res_ovf === 1'bz, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #2;

        // SUM, positive operands, plus issue-to-res_en latency.
        clear_log();
        A = 64'd5;
        set_b_all(64'd1);
        issue(SUM, 0, 1'b0);
        drain();
        check("sum_pos", obs_res[0], 72'd113);
        check("sum_pos_ovf", obs_ovf[0], 1'b0);
        check("latency", en_cyc[0] - issue_cyc, 3);

        // SUM, all minus one.
        clear_log();
        A = '1;
        set_b_all('1);
        issue(SUM, 0, 1'b0);
        drain();
        wrap4 = -109;
        check("sum_neg", obs_res[0], wrap4);

        // Back-to-back channel ops with forwarding through stage 3.
        clear_log();
        set_b_all('0);
        A = 64'd10; issue(LOAD, 2, 1'b0);
        A = 64'd10; issue(ACC, 2, 1'b0);
        A = 64'd7;  issue(ACC, 1, 1'b0);
        issue(RDCLR, 2, 1'b0);
        issue(RDCLR, 2, 1'b0);
        drain();
        check("b2b_count", obs_res.size(), 5);
        check("b2b_load", obs_res[0], 72'd10);
        check("b2b_acc2", obs_res[1], 72'd20);
        check("b2b_acc1", obs_res[2], 72'd7);
        check("b2b_rdclr", obs_res[3], 72'd20);
        check("b2b_rdclr0", obs_res[4], 72'd0);

        // Saturating overflow: the second and third adds both clamp.
        clear_log();
        A = '0;
        set_b_all(64'h7fff_ffff_ffff_ffff);
        issue(LOAD, 0, 1'b1);
        repeat (3) issue(ACC, 0, 1'b1);
        drain();
        check("sat_val", obs_res[3], MAXV[RW-1:0]);
        check("sat_ovf", obs_ovf[3], 1'b1);

        // Wrapping overflow: the second add wraps, the third lands back in range.
        clear_log();
        issue(LOAD, 0, 1'b0);
        repeat (3) issue(ACC, 0, 1'b0);
        drain();
        wrap4 = 72'd432 * 72'h7fff_ffff_ffff_ffff;
        check("wrap_val", obs_res[3], wrap4);
        check("wrap_neg", obs_res[3][RW-1], 1'b1);
        check("wrap_ovf2", obs_ovf[2], 1'b1);
        check("wrap_ovf3", obs_ovf[3], 1'b0);

        // Reset while an op is in flight.
        clear_log();
        set_b_all('0);
        A = 64'd9;
        n_en0 = n_en;
        issue(ACC, 3, 1'b0);
        pulse_reset();
        repeat (6) @(posedge clk);
        #2;
        check("rst_flight_en", n_en - n_en0, 0);
        issue(RDCLR, 3, 1'b0);
        drain();
        check("rst_flight_rdclr", obs_res[0], 72'd0);

        // Random stream at full rate.
        n_en0 = n_en;
        for (int n = 0; n < 1000; n++) begin
            A = {$urandom(), $urandom()};
            for (int i = 0; i < LANES; i++) B[i] = {$urandom(), $urandom()};
            issue(2'($urandom_range(0, 3)), $urandom_range(0, CH-1), 1'($urandom_range(0, 1)));
        end
        drain();
        check("stream_en_count", n_en - n_en0, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
